skid_register: RTL and testbench

Parametrised, edge-triggered storage stage that supersedes our level-sensitive D-latch cells wherever data must cross a valid/ready boundary. It holds up to two WIDTH-bit words (main + skid) so that upstream can be back-pressured with a registered ready while downstream stalls, with no bubbles and no data loss. It sits between any two pipeline stages in the datapath. A parameter selects a single-entry variant with a combinational ready.

---
 rtl/skid_register.sv | 96 +++++++++
 tb/tb_skid_register.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_register.sv
// Valid/ready storage stage: a two-entry skid buffer with a registered in_ready,
// or a single-entry pipeline register with a combinational in_ready when REG_READY=0.
module skid_register #(
    parameter int WIDTH     = 8,
    parameter int REG_READY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [1:0]       occ_q;
    logic             ready_int;
    logic             in_acc;
    logic             out_acc;

    // The single-entry variant can refill in the same cycle it drains, so its
    // ready must look at out_ready directly; the skid variant never does.
    assign ready_int = (REG_READY != 0) ? in_ready_q : (~out_valid_q | out_ready);
    assign in_ready  = ~rst & ready_int;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid_q & out_ready;

    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= EMPTY;
            main_q      <= '0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_acc) begin
                        main_q      <= in_data;
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_acc && out_acc) begin
                        main_q <= in_data;
                    end else if (in_acc && (REG_READY != 0)) begin
                        skid_q     <= in_data;
                        state      <= FULL;
                        occ_q      <= 2'd2;
                        in_ready_q <= 1'b0;
                    end else if (out_acc) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                FULL: begin
                    // The skid word becomes the head; input stays blocked until this pop lands.
                    if (out_acc) begin
                        main_q     <= skid_q;
                        state      <= BUSY;
                        occ_q      <= 2'd1;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: both variants side by side, each tracked by a queue
// model that only knows "capacity, FIFO order, and when ready is offered".
module tb_skid_register;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready1, out_valid1, in_ready0, out_valid0;
    logic [7:0] out_data1, out_data0;
    logic [1:0] occ1, occ0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skid_register #(.WIDTH(8), .REG_READY(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .occupancy(occ1)
    );

    skid_register #(.WIDTH(8), .REG_READY(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .occupancy(occ0)
    );

    // Advance one edge and apply the FIFO rules to both models.
    task automatic tick();
        bit         pop1, push1, pop0, push0;
        logic [7:0] d;
        d     = in_data;
        pop1  = (q1.size() > 0) && out_ready;
        push1 = in_valid && (q1.size() < 2);
        pop0  = (q0.size() > 0) && out_ready;
        push0 = in_valid && ((q0.size() == 0) || out_ready);
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) void'(q1.pop_front());
            if (push1) q1.push_back(d);
            if (pop0) void'(q0.pop_front());
            if (push0) q0.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({in_ready1, out_valid1, out_data1, occ1} !== 12'h000) begin
                errors++;
                $display("[TB] FAIL reset_r1 cyc %0d: in_ready=%b out_valid=%b out_data=%h occ=%0d want 0/0/00/0",
                         i, in_ready1, out_valid1, out_data1, occ1);
            end
            checks++;
            if ({in_ready0, out_valid0, out_data0, occ0} !== 12'h000) begin
                errors++;
                $display("[TB] FAIL reset_r0 cyc %0d: in_ready=%b out_valid=%b out_data=%h occ=%0d want 0/0/00/0",
                         i, in_ready0, out_valid0, out_data0, occ0);
            end
        end
        in_valid = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready1=%b in_ready0=%b want 1/1", in_ready1, in_ready0);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready1 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_ready word %0d: got %b want 1", i, in_ready1);
            end
            if (i > 1) begin
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== 8'(i - 1)) begin
                    errors++;
                    $display("[TB] FAIL stream_out word %0d: got valid=%b data=%h want 1/%h",
                             i, out_valid1, out_data1, 8'(i - 1));
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 8'h10) begin
            errors++;
            $display("[TB] FAIL stream_last: got valid=%b data=%h want 1/10", out_valid1, out_data1);
        end
        tick();
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_drain: got out_valid=%b want 0", out_valid1);
        end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        checks++;
        if (occ1 !== 2'd1 || out_data1 !== 8'h11 || occ0 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL stall_first: occ1=%0d data1=%h occ0=%0d want 1/11/1", occ1, out_data1, occ0);
        end
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_stall_ready: got %b want 0", in_ready0);
        end
        tick();
        checks++;
        if (occ1 !== 2'd2 || in_ready1 !== 1'b0 || occ0 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL stall_full: occ1=%0d in_ready1=%b occ0=%0d want 2/0/1", occ1, in_ready1, occ0);
        end
        in_data = 8'h33;
        tick();
        checks++;
        if (occ1 !== 2'd2 || out_data1 !== 8'h11) begin
            errors++;
            $display("[TB] FAIL stall_hold: occ1=%0d data1=%h want 2/11", occ1, out_data1);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_paths: in_ready0=%b in_ready1=%b want 1/0", in_ready0, in_ready1);
        end
        tick();
        checks++;
        if (out_data1 !== 8'h22 || in_ready1 !== 1'b1 || out_data0 !== 8'h33 || occ0 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL first_pop: data1=%h in_ready1=%b data0=%h occ0=%0d want 22/1/33/1",
                     out_data1, in_ready1, out_data0, occ0);
        end
        tick();
        checks++;
        if (out_data1 !== 8'h33 || occ1 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL second_pop: data1=%h occ1=%0d want 33/1", out_data1, occ1);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || occ0 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stall_drain: occ1=%0d valid1=%b occ0=%0d want 0/0/0", occ1, out_valid1, occ0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        tick();
        in_data = 8'h55;
        tick();
        checks++;
        if (occ1 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL flush_prefill: occ1=%0d want 2", occ1);
        end
        flush = 1'b1; out_ready = 1'b1; in_data = 8'h66;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({occ1, out_valid1, out_data1, occ0, out_valid0, out_data0} !== 22'h0) begin
            errors++;
            $display("[TB] FAIL flush_clear: r1 occ=%0d v=%b d=%h r0 occ=%0d v=%b d=%h want all 0",
                     occ1, out_valid1, out_data1, occ0, out_valid0, out_data0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_ghost cyc %0d: valid1=%b valid0=%b want 0/0", i, out_valid1, out_valid0);
            end
        end
    endtask

    task automatic test_random_backpressure();
        logic       prev_stall1 = 1'b0, prev_stall0 = 1'b0;
        logic [7:0] prev_data1 = 8'h00, prev_data0 = 8'h00;
        for (int n = 0; n < 1000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            #1;
            checks++;
            if (out_valid1 !== (q1.size() > 0) || occ1 !== 2'(q1.size()) || in_ready1 !== (q1.size() < 2) ||
                (q1.size() > 0 && out_data1 !== q1[0])) begin
                errors++;
                $display("[TB] FAIL rand_r1 cyc %0d: v=%b occ=%0d rdy=%b d=%h want v=%b occ=%0d rdy=%b d=%h",
                         n, out_valid1, occ1, in_ready1, out_data1, q1.size() > 0, q1.size(), q1.size() < 2,
                         (q1.size() > 0) ? q1[0] : 8'h00);
            end
            checks++;
            if (out_valid0 !== (q0.size() > 0) || occ0 !== 2'(q0.size()) ||
                in_ready0 !== ((q0.size() == 0) || out_ready) || (q0.size() > 0 && out_data0 !== q0[0])) begin
                errors++;
                $display("[TB] FAIL rand_r0 cyc %0d: v=%b occ=%0d rdy=%b d=%h want v=%b occ=%0d d=%h",
                         n, out_valid0, occ0, in_ready0, out_data0, q0.size() > 0, q0.size(),
                         (q0.size() > 0) ? q0[0] : 8'h00);
            end
            checks++;
            if ((prev_stall1 && out_data1 !== prev_data1) || (prev_stall0 && out_data0 !== prev_data0)) begin
                errors++;
                $display("[TB] FAIL rand_stable cyc %0d: d1=%h was %h d0=%h was %h",
                         n, out_data1, prev_data1, out_data0, prev_data0);
            end
            prev_stall1 = out_valid1 && !out_ready;
            prev_stall0 = out_valid0 && !out_ready;
            prev_data1  = out_data1;
            prev_data0  = out_data0;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_random_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
